// File: rtl/hsi_vector_core_ctrl_mc.sv
// hsi_vector_core_ctrl_mc: OBI register block controlling NUM_CH vector-core channels
module hsi_vector_core_ctrl_mc #(
    parameter int NUM_CH          = 4,
    parameter int OP_CODE_WIDTH   = 8,
    parameter int NUM_BANDS_WIDTH = 8,
    parameter int ERR_WIDTH       = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_i,
    input  logic                                we_i,
    input  logic [3:0]                          be_i,
    input  logic [31:0]                         addr_i,
    input  logic [31:0]                         wdata_i,
    output logic                                gnt_o,
    output logic                                rvalid_o,
    output logic [31:0]                         rdata_o,
    output logic                                err_o,
    output logic [NUM_CH*OP_CODE_WIDTH-1:0]     op_code_o,
    output logic [NUM_CH*NUM_BANDS_WIDTH-1:0]   num_bands_o,
    output logic [NUM_CH-1:0]                   start_o,
    input  logic [NUM_CH-1:0]                   pixel_done_i,
    input  logic [NUM_CH*ERR_WIDTH-1:0]         error_code_i,
    output logic                                irq_o
);
    logic                       rsp_pending;
    logic [OP_CODE_WIDTH-1:0]   op_code [NUM_CH];
    logic [NUM_BANDS_WIDTH-1:0] num_bands [NUM_CH];
    logic [ERR_WIDTH-1:0]       err_code [NUM_CH];
    logic [15:0]                nb_new [NUM_CH];
    logic [NUM_CH-1:0]          irq_en, done, busy, overrun, pend;
    logic [NUM_CH-1:0]          wsel, start_acc, start_ovr, done_clr, ovr_clr;
    logic [3:0]                 ch;
    logic [1:0]                 reg_sel;
    logic                       bad, wr;
    logic [31:0]                rd_val;
    logic                       unused;

    assign unused  = ^{addr_i[31:9], wdata_i[31:16], be_i[3:2]};
    assign ch      = addr_i[7:4];
    assign reg_sel = addr_i[3:2];
    assign bad     = (addr_i[1:0] != 2'b00) |
                     (addr_i[8] ? ((addr_i[7:0] != 8'h00) | we_i) : (int'(ch) >= NUM_CH));
    assign gnt_o   = req_i & ~rsp_pending & ~rst_i;
    assign wr      = gnt_o & we_i & ~bad & ~addr_i[8];
    assign pend    = done & irq_en;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign op_code_o[g*OP_CODE_WIDTH +: OP_CODE_WIDTH]       = op_code[g];
        assign num_bands_o[g*NUM_BANDS_WIDTH +: NUM_BANDS_WIDTH] = num_bands[g];
    end

    // Decode the current request into per-channel write strobes and read data
    always_comb begin
        rd_val    = addr_i[8] ? 32'(pend) : '0;
        wsel      = '0;
        done_clr  = '0;
        ovr_clr   = '0;
        start_acc = '0;
        start_ovr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nb_new[c]    = 16'(num_bands[c]);
            nb_new[c]    = {be_i[1] ? wdata_i[15:8] : nb_new[c][15:8], be_i[0] ? wdata_i[7:0] : nb_new[c][7:0]};
            wsel[c]      = wr && int'(ch) == c;
            start_acc[c] = wsel[c] && reg_sel == 2'd2 && be_i[0] && wdata_i[0] && !busy[c];
            start_ovr[c] = wsel[c] && reg_sel == 2'd2 && be_i[0] && wdata_i[0] && busy[c];
            done_clr[c]  = wsel[c] && reg_sel == 2'd3 && be_i[0] && wdata_i[0];
            ovr_clr[c]   = wsel[c] && reg_sel == 2'd3 && be_i[0] && wdata_i[2];
            if (!addr_i[8] && int'(ch) == c)
                rd_val = reg_sel == 2'd0 ? 32'(op_code[c]) :
                         reg_sel == 2'd1 ? 32'(num_bands[c]) :
                         reg_sel == 2'd2 ? {30'b0, irq_en[c], 1'b0} :
                         (32'(err_code[c]) << 8) | {29'b0, overrun[c], busy[c], done[c]};
        end
    end

    // Bus response, start pulses, interrupt and per-channel register state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pending <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            start_o     <= '0;
            irq_o       <= 1'b0;
            irq_en      <= '0;
            done        <= '0;
            busy        <= '0;
            overrun     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                op_code[c]   <= '0;
                num_bands[c] <= '0;
                err_code[c]  <= '0;
            end
        end else begin
            rsp_pending <= gnt_o;
            rvalid_o    <= gnt_o;
            rdata_o     <= (gnt_o && !we_i && !bad) ? rd_val : '0;
            err_o       <= gnt_o & bad;
            start_o     <= start_acc;
            irq_o       <= |pend;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wsel[c] && reg_sel == 2'd0 && be_i[0])
                    op_code[c] <= wdata_i[OP_CODE_WIDTH-1:0];
                if (wsel[c] && reg_sel == 2'd1)
                    num_bands[c] <= nb_new[c][NUM_BANDS_WIDTH-1:0];
                if (wsel[c] && reg_sel == 2'd2 && be_i[0])
                    irq_en[c] <= wdata_i[1];
                if (start_acc[c])
                    done[c] <= 1'b0;
                else if (pixel_done_i[c])
                    done[c] <= 1'b1;
                else if (done_clr[c])
                    done[c] <= 1'b0;
                if (start_acc[c])
                    busy[c] <= 1'b1;
                else if (pixel_done_i[c])
                    busy[c] <= 1'b0;
                if (start_acc[c])
                    err_code[c] <= '0;
                else if (pixel_done_i[c])
                    err_code[c] <= error_code_i[c*ERR_WIDTH +: ERR_WIDTH];
                if (start_ovr[c])
                    overrun[c] <= 1'b1;
                else if (ovr_clr[c])
                    overrun[c] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hsi_vector_core_ctrl_mc.sv
// tb_hsi_vector_core_ctrl_mc: scoreboard bench with a behavioural register model
module tb_hsi_vector_core_ctrl_mc;
    localparam int NC = 4, OW = 8, NW = 16, EW = 8;

    logic clk = 0, rst = 1, req = 0, we = 0;
    logic [3:0] be = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic gnt, rvalid, err, irq;
    logic [31:0] rdata;
    logic [NC*OW-1:0] op_code;
    logic [NC*NW-1:0] num_bands;
    logic [NC-1:0] start, pdone = '0;
    logic [NC*EW-1:0] ecode = '0;

    int n_cmp = 0, n_bad = 0, start_cnt2 = 0;
    bit mon_en = 0;
    int m_op[NC], m_nb[NC], m_ien[NC], m_done[NC], m_busy[NC], m_ovr[NC], m_err[NC], m_start[NC];
    bit m_irq = 0, m_pend_rsp = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    hsi_vector_core_ctrl_mc #(.NUM_CH(NC), .OP_CODE_WIDTH(OW), .NUM_BANDS_WIDTH(NW), .ERR_WIDTH(EW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .op_code_o(op_code), .num_bands_o(num_bands), .start_o(start),
        .pixel_done_i(pdone), .error_code_i(ecode), .irq_o(irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*OW-1:0] exp_op();
        logic [NC*OW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*OW +: OW] = OW'(m_op[k]);
        return r;
    endfunction

    function automatic logic [NC*NW-1:0] exp_nb();
        logic [NC*NW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*NW +: NW] = NW'(m_nb[k]);
        return r;
    endfunction

    function automatic logic [NC-1:0] exp_start();
        logic [NC-1:0] r;
        for (int k = 0; k < NC; k++) r[k] = m_start[k] != 0;
        return r;
    endfunction

    // Model of one clock edge, applied with the inputs that were present at that edge
    task automatic model_edge(input bit g);
        int c, r, rd, pend, ob;
        bit glob, bad, start_req;
        c = int'(addr[7:4]);
        r = int'(addr[3:2]);
        glob = addr[8];
        bad = addr[1:0] != 0 || (glob ? (addr[7:0] != 0 || we) : c >= NC);
        rd = 0; pend = 0; start_req = 0;
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                m_op[k] = 0; m_nb[k] = 0; m_ien[k] = 0; m_done[k] = 0;
                m_busy[k] = 0; m_ovr[k] = 0; m_err[k] = 0; m_start[k] = 0;
            end
            exp_q.delete();
            m_pend_rsp = 0;
            m_irq = 0;
            return;
        end
        for (int k = 0; k < NC; k++) begin
            if (m_done[k] != 0 && m_ien[k] != 0) pend += 1 << k;
            m_start[k] = 0;
        end
        m_irq = pend != 0;
        m_pend_rsp = g;
        ob = (c < NC) ? m_busy[c] : 0;
        if (g) begin
            if (!bad && !we)
                rd = glob ? pend : r == 0 ? m_op[c] : r == 1 ? m_nb[c] : r == 2 ? m_ien[c] * 2 :
                     m_err[c] * 256 + m_ovr[c] * 4 + m_busy[c] * 2 + m_done[c];
            exp_q.push_back({bad, 32'(rd)});
            if (we && !bad) begin
                if (r == 0 && be[0]) m_op[c] = int'(wdata[7:0]);
                if (r == 1) m_nb[c] = ((be[1] ? int'(wdata[15:8]) : (m_nb[c] >> 8)) << 8) |
                                      (be[0] ? int'(wdata[7:0]) : (m_nb[c] & 255));
                if (r == 2 && be[0]) begin
                    m_ien[c] = int'(wdata[1]);
                    start_req = wdata[0];
                end
                if (r == 3 && be[0]) begin
                    if (wdata[0]) m_done[c] = 0;
                    if (wdata[2]) m_ovr[c] = 0;
                end
            end
        end
        for (int k = 0; k < NC; k++)
            if (pdone[k]) begin
                m_done[k] = 1;
                m_busy[k] = 0;
                m_err[k] = int'(ecode[k*EW +: EW]);
            end
        if (start_req) begin
            if (ob != 0) m_ovr[c] = 1;
            else begin
                m_busy[c] = 1; m_done[c] = 0; m_err[c] = 0; m_start[c] = 1;
            end
        end
    endtask

    // Monitor: pops expected responses on rvalid and compares live outputs with the model
    always @(negedge clk) begin
        logic [32:0] e;
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rvalid", rvalid, 1);
                chk("rdata", rdata, e[31:0]);
                chk("err", err, e[32]);
            end else if (rvalid) chk("rvalid_spurious", rvalid, 0);
            chk("op_code_o", op_code, exp_op());
            chk("num_bands_o", num_bands, exp_nb());
            chk("start_o", start, exp_start());
            chk("irq_o", irq, m_irq);
            if (start[2]) start_cnt2++;
        end
    end

    task automatic cycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [NC-1:0] pd, input logic [NC*EW-1:0] ec);
        bit eg;
        @(negedge clk);
        #1;
        req = r; we = w; addr = a; wdata = d; be = b; pdone = pd; ecode = ec;
        #1;
        eg = r && !m_pend_rsp && !rst;
        chk("gnt_o", gnt, eg);
        @(posedge clk);
        #1;
        model_edge(eg);
    endtask

    task automatic idle();
        cycle(0, 0, '0, '0, '0, '0, '0);
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] erd, input bit eerr, input string nm);
        cycle(1, w, a, d, b, '0, '0);
        chk({nm, "_rvalid"}, rvalid, 1);
        chk({nm, "_rdata"}, rdata, erd);
        chk({nm, "_err"}, err, eerr);
        idle();
    endtask

    initial begin
        logic [31:0] a, d;
        logic [NC-1:0] pd;
        cycle(1, 0, 32'h10, '0, 4'hF, '0, '0);
        idle();
        mon_en = 1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_irq", irq, 0);
        chk("rst_op", op_code, 0);
        chk("rst_start", start, 0);
        rst = 0;
        idle();

        xfer(1, 32'h10, 32'h05, 4'hF, 0, 0, "wr_op1");
        xfer(0, 32'h10, 0, 4'hF, 32'h5, 0, "rd_op1");
        chk("op1_vector", op_code, 32'h0000_0500);

        start_cnt2 = 0;
        xfer(1, 32'h28, 32'h1, 4'h1, 0, 0, "start2_a");
        xfer(1, 32'h28, 32'h1, 4'h1, 0, 0, "start2_b");
        xfer(0, 32'h2C, 0, 4'hF, 32'h6, 0, "rd_status2");
        chk("start2_pulses", start_cnt2, 1);

        xfer(1, 32'h18, 32'h2, 4'h1, 0, 0, "ien1");
        xfer(1, 32'h18, 32'h3, 4'h1, 0, 0, "start1");
        cycle(0, 0, '0, '0, '0, 4'b0010, 32'h0000_3C00);
        idle();
        xfer(0, 32'h1C, 0, 4'hF, 32'h3C01, 0, "rd_status1");
        xfer(0, 32'h100, 0, 4'hF, 32'h2, 0, "rd_pend");
        chk("irq_set", irq, 1);
        xfer(1, 32'h1C, 32'h1, 4'h1, 0, 0, "w1c_done1");
        chk("irq_clr", irq, 0);

        xfer(0, 32'h40, 0, 4'hF, 0, 1, "bad_ch");
        xfer(1, 32'h02, 32'hFF, 4'hF, 0, 1, "bad_align");
        xfer(1, 32'h100, 32'hF, 4'hF, 0, 1, "wr_pend");

        xfer(1, 32'h04, 32'hABCD, 4'b0010, 0, 0, "wr_nb0");
        xfer(0, 32'h04, 0, 4'hF, 32'hAB00, 0, "rd_nb0");

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            a[8] = 0;
            a[7:4] = 4'($urandom_range(0, NC - 1));
            a[1:0] = 0;
            if ($urandom_range(0, 9) == 8) a = 32'h100;
            if ($urandom_range(0, 9) == 9) a = $urandom;
            d = $urandom;
            pd = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, d, 4'($urandom), pd, $urandom);
        end

        xfer(1, 32'h30, 32'h7, 4'hF, 0, 0, "pre_rst_wr");
        rst = 1;
        cycle(1, 0, 32'h30, '0, 4'hF, '0, '0);
        chk("rst2_rvalid", rvalid, 0);
        chk("rst2_op", op_code, 0);
        chk("rst2_nb", num_bands, 0);
        chk("rst2_irq", irq, 0);
        rst = 0;
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
